cell_sweep_ctrl: RTL

CELL_SWEEP_CTRL -- requirements
Module: cell_sweep_ctrl

---
 rtl/cell_sweep_ctrl_pkg.sv | 20 ++
 rtl/aoi222_golden.sv | 11 +
 rtl/cell_sweep_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cell_sweep_ctrl_pkg.sv
// Shared definitions for the AOI222 cell sweep controller: sizes, FSM states
// and the golden AOI222 response function.
package cell_sweep_ctrl_pkg;

  localparam int VEC_W   = 6;
  localparam int NUM_VEC = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // vec = {A1,A2,B1,B2,C1,C2}; ZN = ~((A1&A2)|(B1&B2)|(C1&C2))
  function automatic logic aoi222_exp(input logic [VEC_W-1:0] v);
    return ~((v[5] & v[4]) | (v[3] & v[2]) | (v[1] & v[0]));
  endfunction

endpackage

// File: rtl/aoi222_golden.sv
// Combinational golden model of the AOI222 cell: expected ZN for a stimulus vector.
module aoi222_golden
  import cell_sweep_ctrl_pkg::*;
(
  input  logic [VEC_W-1:0] vec_i,
  output logic             exp_o
);

  assign exp_o = aoi222_exp(vec_i);

endmodule

// File: rtl/cell_sweep_ctrl.sv
// Sweeps all 64 AOI222 input vectors, lets each settle, samples ZN against the
// golden response and records error count, first failing vector and pass/fail.
module cell_sweep_ctrl
  import cell_sweep_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [VEC_W-1:0] vec,
  input  logic             zn_in,
  output logic             busy,
  output logic             done,
  output logic [6:0]       err_count,
  output logic             pass,
  output logic [VEC_W-1:0] first_fail_vec,
  output logic             first_fail_valid
);

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] VEC_LAST    = VEC_W'(NUM_VEC - 1);

  state_e           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [6:0]       err_q, err_d;
  logic             pass_q, pass_d;
  logic [VEC_W-1:0] ffv_vec_q, ffv_vec_d;
  logic             ffv_q, ffv_d;
  logic             exp_zn;

  aoi222_golden u_golden (
    .vec_i (vec_q),
    .exp_o (exp_zn)
  );

  // NOTE: every next-state signal gets its hold value first so no path leaves
  // it unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    pass_d    = pass_q;
    ffv_vec_d = ffv_vec_q;
    ffv_d     = ffv_q;

    if (abort) begin
      // Results survive an abort for inspection, but a partial sweep never passes.
      state_d = ST_IDLE;
      vec_d   = '0;
      cnt_d   = '0;
      pass_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_SETTLE;
            vec_d   = '0;
            cnt_d   = '0;
            err_d   = '0;
            ffv_d   = 1'b0;
            pass_d  = 1'b0;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == SETTLE_LAST) state_d = ST_SAMPLE;
          else                      cnt_d   = cnt_q + 4'd1;
        end
        ST_SAMPLE: begin
          if (zn_in != exp_zn) begin
            err_d = err_q + 7'd1;
            if (!ffv_q) begin
              ffv_vec_d = vec_q;
              ffv_d     = 1'b1;
            end
          end
          if (vec_q == VEC_LAST) begin
            // err_d already includes a mismatch on the final vector.
            state_d = ST_DONE;
            pass_d  = (err_d == 7'd0);
          end else begin
            state_d = ST_SETTLE;
            vec_d   = vec_q + VEC_W'(1);
            cnt_d   = '0;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      vec_q     <= '0;
      cnt_q     <= '0;
      err_q     <= '0;
      pass_q    <= 1'b0;
      ffv_vec_q <= '0;
      ffv_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      pass_q    <= pass_d;
      ffv_vec_q <= ffv_vec_d;
      ffv_q     <= ffv_d;
    end
  end

  assign vec              = vec_q;
  assign busy             = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign done             = (state_q == ST_DONE);
  assign err_count        = err_q;
  assign pass             = pass_q;
  assign first_fail_vec   = ffv_vec_q;
  assign first_fail_valid = ffv_q;

endmodule
